req_queue: RTL and testbench

- Upstream feeder for the 3-way `Arbiter`.
- Three independent client FIFOs hold pending transaction words.
- Each non-empty FIFO raises its `req` bit toward the arbiter. A returned `grant` bit pops one word from that client's FIFO.
- The popped word, tagged with its source, is presented on a single registered output channel to the shared resource.

---
 rtl/req_queue.sv | 120 ++++++++++++
 tb/tb_req_queue.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/req_queue.sv
// Three client FIFOs feeding a 3-way arbiter; granted words leave on one registered, source-tagged channel.
// Optional macro REQ_QUEUE_LEVEL_EN adds the per-client occupancy output `level`.
module req_queue #(
    parameter int DW    = 8,
    parameter int DEPTH = 4
) (
    input  logic                                clk,
    input  logic                                res_n,
    input  logic [2:0]                          push,
    input  logic [3*DW-1:0]                     push_data,
    output logic [2:0]                          full,
    output logic [2:0]                          req,
    input  logic [2:0]                          grant,
    output logic                                out_valid,
    output logic [DW-1:0]                       out_data,
    output logic [2:0]                          out_src,
    output logic                                overflow,
    output logic                                grant_err
`ifdef REQ_QUEUE_LEVEL_EN
    ,
    output logic [3*($clog2(DEPTH)+1)-1:0]      level
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   CNT_MAX = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    logic [DW-1:0] mem [3][DEPTH];
    logic [AW-1:0] wptr [3];
    logic [AW-1:0] rptr [3];
    logic [AW:0]   cnt  [3];
    logic [2:0]    req_prev;

    logic          multi_grant;
    logic [2:0]    pop;
    logic [2:0]    wr;
    logic [2:0]    drop;
    logic [2:0]    stray_grant;
    logic [DW-1:0] pop_data;

    assign multi_grant = (grant & (grant - 3'd1)) != 3'd0;

    always_comb begin
        pop_data = '0;
        for (int i = 0; i < 3; i++) begin
            req[i]         = cnt[i] != '0;
            full[i]        = cnt[i] == CNT_MAX;
            pop[i]         = grant[i] & ~multi_grant & req[i];
            wr[i]          = push[i] & (~full[i] | pop[i]);
            drop[i]        = push[i] & full[i] & ~pop[i];
            // Holding grant for one cycle past the last word is normal arbiter behaviour.
            stray_grant[i] = grant[i] & ~req[i] & ~req_prev[i];
            if (pop[i]) begin
                pop_data = mem[i][rptr[i]];
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (wr[i]) begin
                mem[i][wptr[i]] <= push_data[i*DW +: DW];
            end
        end
    end

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            for (int i = 0; i < 3; i++) begin
                wptr[i] <= '0;
                rptr[i] <= '0;
                cnt[i]  <= '0;
            end
            req_prev  <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= '0;
            overflow  <= 1'b0;
            grant_err <= 1'b0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (wr[i]) begin
                    wptr[i] <= wptr[i] + PTR_ONE;
                end
                if (pop[i]) begin
                    rptr[i] <= rptr[i] + PTR_ONE;
                end
                if (wr[i] && !pop[i]) begin
                    cnt[i] <= cnt[i] + CNT_ONE;
                end else if (pop[i] && !wr[i]) begin
                    cnt[i] <= cnt[i] - CNT_ONE;
                end
            end
            req_prev  <= req;
            out_valid <= pop != 3'd0;
            out_src   <= pop;
            if (pop != 3'd0) begin
                out_data <= pop_data;
            end
            if (drop != 3'd0) begin
                overflow <= 1'b1;
            end
            if (multi_grant || stray_grant != 3'd0) begin
                grant_err <= 1'b1;
            end
        end
    end

`ifdef REQ_QUEUE_LEVEL_EN
    always_comb begin
        level = '0;
        for (int i = 0; i < 3; i++) begin
            level[i*(AW+1) +: AW+1] = cnt[i];
        end
    end
`endif

endmodule

// File: tb/tb_req_queue.sv
// Directed and randomized bench for req_queue, checked against a queue-based reference model.
module tb_req_queue;

    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int AW    = $clog2(DEPTH);

    logic          clk = 1'b0;
    logic          res_n;
    logic [2:0]    push;
    logic [3*DW-1:0] push_data;
    logic [2:0]    full;
    logic [2:0]    req;
    logic [2:0]    grant;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic [2:0]    out_src;
    logic          overflow;
    logic          grant_err;
`ifdef REQ_QUEUE_LEVEL_EN
    logic [3*(AW+1)-1:0] level;
`endif

    req_queue #(.DW(DW), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .res_n     (res_n),
        .push      (push),
        .push_data (push_data),
        .full      (full),
        .req       (req),
        .grant     (grant),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_src   (out_src),
        .overflow  (overflow),
        .grant_err (grant_err)
`ifdef REQ_QUEUE_LEVEL_EN
        ,
        .level     (level)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: one plain queue per client plus expected output registers.
    logic [DW-1:0] mq [3][$];
    logic          m_valid;
    logic [DW-1:0] m_data;
    logic [2:0]    m_src;
    logic          m_ovf;
    logic          m_gerr;
    logic [2:0]    m_prev_req;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) mq[i].delete();
        m_valid = 1'b0; m_data = '0; m_src = '0;
        m_ovf = 1'b0; m_gerr = 1'b0; m_prev_req = '0;
    endtask

    task automatic model_edge(input logic [2:0] p, input logic [3*DW-1:0] d, input logic [2:0] g);
        bit multi;
        bit popped [3];
        bit was_full [3];
        logic [2:0] now_req;
        multi = $countones(g) >= 2;
        m_valid = 1'b0;
        m_src   = '0;
        if (multi) m_gerr = 1'b1;
        for (int i = 0; i < 3; i++) begin
            now_req[i]  = mq[i].size() != 0;
            was_full[i] = mq[i].size() == DEPTH;
            popped[i]   = 1'b0;
            if (g[i] && !now_req[i] && !m_prev_req[i]) m_gerr = 1'b1;
            if (!multi && g[i] && now_req[i]) begin
                m_data    = mq[i].pop_front();
                m_valid   = 1'b1;
                m_src     = 3'(1 << i);
                popped[i] = 1'b1;
            end
        end
        for (int i = 0; i < 3; i++) begin
            if (p[i]) begin
                if (!was_full[i] || popped[i]) mq[i].push_back(d[i*DW +: DW]);
                else m_ovf = 1'b1;
            end
        end
        m_prev_req = now_req;
    endtask

    task automatic check_all();
        logic [2:0] er;
        logic [2:0] ef;
        for (int i = 0; i < 3; i++) begin
            er[i] = mq[i].size() != 0;
            ef[i] = mq[i].size() == DEPTH;
        end
        chk("out_valid", 32'(out_valid), 32'(m_valid));
        chk("out_src",   32'(out_src),   32'(m_src));
        chk("out_data",  32'(out_data),  32'(m_data));
        chk("req",       32'(req),       32'(er));
        chk("full",      32'(full),      32'(ef));
        chk("overflow",  32'(overflow),  32'(m_ovf));
        chk("grant_err", 32'(grant_err), 32'(m_gerr));
`ifdef REQ_QUEUE_LEVEL_EN
        for (int i = 0; i < 3; i++)
            chk("level", 32'(level[i*(AW+1) +: AW+1]), 32'(mq[i].size()));
`endif
    endtask

    task automatic cycle(input logic [2:0] p, input logic [3*DW-1:0] d, input logic [2:0] g);
        @(negedge clk);
        push = p; push_data = d; grant = g;
        @(posedge clk);
        model_edge(p, d, g);
        #1;
        check_all();
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_req"},       32'(req),       32'd0);
        chk({tag, "_full"},      32'(full),      32'd0);
        chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_out_src"},   32'(out_src),   32'd0);
        chk({tag, "_out_data"},  32'(out_data),  32'd0);
        chk({tag, "_overflow"},  32'(overflow),  32'd0);
        chk({tag, "_grant_err"}, 32'(grant_err), 32'd0);
    endtask

    initial begin
        logic [2:0] g;
        int r;
        res_n = 1'b0; push = 3'b111; push_data = 24'hA5A5A5; grant = 3'b000;
        model_reset();

        // Reset held for 100 ns with pushes active.
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            check_reset_outputs("rst");
        end
        @(negedge clk);
        res_n = 1'b1; push = 3'b000;
        #1 chk("rst_release_req", 32'(req), 32'd0);
        cycle(3'b000, '0, 3'b000);

        // Fill and drain client 0, then hold grant one cycle past empty.
        cycle(3'b001, 24'h000011, 3'b000);
        cycle(3'b001, 24'h000022, 3'b000);
        cycle(3'b001, 24'h000033, 3'b000);
        cycle(3'b001, 24'h000044, 3'b000);
        for (int k = 0; k < 5; k++) cycle(3'b000, '0, 3'b001);
        cycle(3'b000, '0, 3'b000);

        // Overflow on client 1, then full push with simultaneous pop.
        for (int k = 0; k < 4; k++) cycle(3'b010, 24'((k + 1) << 8), 3'b000);
        cycle(3'b010, 24'h005500, 3'b000);
        cycle(3'b010, 24'h006600, 3'b010);
        for (int k = 0; k < 5; k++) cycle(3'b000, '0, 3'b010);
        cycle(3'b000, '0, 3'b000);

        // Interleaved clients.
        cycle(3'b111, 24'hC0B0A0, 3'b000);
        cycle(3'b010, 24'h00B100, 3'b000);
        cycle(3'b000, '0, 3'b100);
        cycle(3'b000, '0, 3'b010);
        cycle(3'b000, '0, 3'b010);
        cycle(3'b000, '0, 3'b001);
        cycle(3'b000, '0, 3'b000);

        // Wrap-around on client 2: push on steps 0..2, pop on steps 2 and 4 of each five.
        for (int k = 0; k < 10; k++)
            cycle(((k % 5) <= 2) ? 3'b100 : 3'b000, 24'(($urandom_range(0, 255)) << 16),
                  ((k % 5) == 2 || (k % 5) == 4) ? 3'b100 : 3'b000);
        for (int k = 0; k < 4; k++) cycle(3'b000, '0, 3'b100);
        cycle(3'b000, '0, 3'b000);

        // Illegal multi-bit grant, then sticky check.
        cycle(3'b011, 24'h0077EE, 3'b000);
        cycle(3'b000, '0, 3'b011);
        for (int k = 0; k < 3; k++) cycle(3'b000, '0, 3'b000);

        // Asynchronous reset mid-stream discards queued words and clears flags.
        cycle(3'b111, 24'h123456, 3'b000);
        @(posedge clk);
        #2 res_n = 1'b0;
        #1 check_reset_outputs("async_rst");
        model_reset();
        @(negedge clk);
        res_n = 1'b1; push = 3'b000; grant = 3'b000;
        #1 chk("async_release_req", 32'(req), 32'd0);
        cycle(3'b000, '0, 3'b000);

        // Randomized traffic, mostly legal one-hot grants.
        for (int k = 0; k < 400; k++) begin
            r = $urandom_range(0, 19);
            if (r == 0)      g = 3'($urandom_range(0, 7));
            else if (r < 6)  g = 3'b000;
            else             g = 3'(1 << $urandom_range(0, 2));
            cycle(3'($urandom_range(0, 7)), 24'($urandom), g);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
